// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for the shared-bus multicycle RV32I datapath. Every instruction
// runs through a fetch (PC -> MA, memory -> IR), a decode cycle, an execute
// phase over the single 32-bit bus, and a common PC-update tail that adds
// either the constant 4 or the B-type immediate to the PC.
//
// Supported: R-type ALU, I-type ALU, LW, SW, BEQ/BNE. Any other encoding
// parks the controller in HALT until reset.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   instr[31:0]    in   current IR contents from the datapath
//   zero           in   ALU zero flag (combinational)
//   busy           in   memory busy; data valid / write complete when 0
//   ALUControl[3:0] out ALU operation
//   lda/ldb        out  load A / B register from the bus
//   ldma           out  load memory-address register from the bus
//   ldiR           out  load IR from the bus
//   reg_sel[1:0]   out  register-file address: 0=rs1 1=rs2 2=rd 3=PC
//   reg_en/reg_we  out  register-file enable / write enable
//   mem_en/mem_we  out  memory enable / write enable
//   alu_en         out  ALU result drives the bus
//   IMM_en         out  immediate drives the bus
//   ExtendSign_sel[1:0] out immediate select: 00=I 01=S 10=B 11=const 4
//   instr_done     out  one-cycle pulse on the last cycle of an instruction
//   halted         out  high while in HALT
// -----------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        busy,
  output logic [3:0]  ALUControl,
  output logic        lda,
  output logic        ldb,
  output logic        ldma,
  output logic        ldiR,
  output logic [1:0]  reg_sel,
  output logic        reg_en,
  output logic        reg_we,
  output logic        mem_en,
  output logic        mem_we,
  output logic        alu_en,
  output logic        IMM_en,
  output logic [1:0]  ExtendSign_sel,
  output logic        instr_done,
  output logic        halted
);

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  // Register-file address selects
  localparam logic [1:0] SEL_RS1 = 2'd0;
  localparam logic [1:0] SEL_RS2 = 2'd1;
  localparam logic [1:0] SEL_RD  = 2'd2;
  localparam logic [1:0] SEL_PC  = 2'd3;

  // Immediate selects
  localparam logic [1:0] IMM_I    = 2'b00;
  localparam logic [1:0] IMM_S    = 2'b01;
  localparam logic [1:0] IMM_B    = 2'b10;
  localparam logic [1:0] IMM_FOUR = 2'b11;

  typedef enum logic [4:0] {
    S_RESET    = 5'd0,
    S_FETCH_MA = 5'd1,
    S_FETCH_IR = 5'd2,
    S_DECODE   = 5'd3,
    S_RS1_A    = 5'd4,
    S_RS2_B    = 5'd5,
    S_IMM_B    = 5'd6,
    S_ALU_WB   = 5'd7,
    S_ADDR_MA  = 5'd8,
    S_MEM_RD   = 5'd9,
    S_MEM_WR   = 5'd10,
    S_CMP      = 5'd11,
    S_PCB_A    = 5'd12,
    S_PCB_B    = 5'd13,
    S_PCB_WB   = 5'd14,
    S_PCI_A    = 5'd15,
    S_PCI_B    = 5'd16,
    S_PCI_WB   = 5'd17,
    S_HALT     = 5'd18
  } state_t;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BR   = 3'd4,
    CLS_HALT = 3'd5
  } cls_t;

  // Classify an instruction word; anything outside the subset halts.
  function automatic cls_t decode_class(input logic [31:0] ir);
    cls_t cls;
    cls = CLS_HALT;
    case (ir[6:0])
      7'b0110011: cls = CLS_R;
      7'b0010011: cls = CLS_I;
      7'b0000011: cls = (ir[14:12] == 3'b010) ? CLS_LW : CLS_HALT;
      7'b0100011: cls = (ir[14:12] == 3'b010) ? CLS_SW : CLS_HALT;
      7'b1100011: cls = (ir[14:13] == 2'b00) ? CLS_BR : CLS_HALT;
      default:    cls = CLS_HALT;
    endcase
    return cls;
  endfunction

  // ALU op held for the instruction. instr[30] only picks SUB for R-type
  // funct3=000 (so ADDI with imm[10] set stays ADD) and SRA/SRAI for 101.
  // Loads/stores hold ADD, branches hold SUB; funct3=011 (no unsigned
  // compare in this ALU) falls back to SLT.
  function automatic logic [3:0] decode_alu(input logic [31:0] ir, input cls_t cls);
    logic [3:0] op;
    op = ALU_ADD;
    case (cls)
      CLS_R, CLS_I: begin
        case (ir[14:12])
          3'b000:  op = ((cls == CLS_R) && ir[30]) ? ALU_SUB : ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLT;
          3'b100:  op = ALU_XOR;
          3'b101:  op = ir[30] ? ALU_SRA : ALU_SRL;
          3'b110:  op = ALU_OR;
          3'b111:  op = ALU_AND;
          default: op = ALU_ADD;
        endcase
      end
      CLS_BR:  op = ALU_SUB;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  state_t     state_q, state_d;
  cls_t       cls_q, cls_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic       bne_q, bne_d;
  logic       rd_zero_q, rd_zero_d;

  cls_t       dec_cls_s;
  logic       taken_s;
  logic       unused_instr_bits_s;

  assign dec_cls_s = decode_class(instr);
  // funct3[0] distinguishes BNE from BEQ; decided against zero in CMP.
  assign taken_s   = bne_q ? ~zero : zero;
  // Immediate/register fields are consumed by the datapath, not here.
  assign unused_instr_bits_s = ^{instr[31], instr[29:15]};

  // State register and decoded-instruction fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET;
      cls_q     <= CLS_HALT;
      alu_op_q  <= ALU_ADD;
      bne_q     <= 1'b0;
      rd_zero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      alu_op_q  <= alu_op_d;
      bne_q     <= bne_d;
      rd_zero_q <= rd_zero_d;
    end
  end

  // Capture instruction class, ALU op, branch sense and rd==x0 in DECODE.
  always_comb begin
    cls_d     = cls_q;
    alu_op_d  = alu_op_q;
    bne_d     = bne_q;
    rd_zero_d = rd_zero_q;
    if (state_q == S_DECODE) begin
      cls_d     = dec_cls_s;
      alu_op_d  = decode_alu(instr, dec_cls_s);
      bne_d     = instr[12];
      rd_zero_d = (instr[11:7] == 5'd0);
    end else begin
      cls_d     = cls_q;
      alu_op_d  = alu_op_q;
      bne_d     = bne_q;
      rd_zero_d = rd_zero_q;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:    state_d = S_FETCH_MA;
      S_FETCH_MA: state_d = S_FETCH_IR;
      S_FETCH_IR: state_d = busy ? S_FETCH_IR : S_DECODE;
      S_DECODE:   state_d = (dec_cls_s == CLS_HALT) ? S_HALT : S_RS1_A;
      S_RS1_A:    state_d = ((cls_q == CLS_R) || (cls_q == CLS_BR)) ? S_RS2_B : S_IMM_B;
      S_RS2_B:    state_d = (cls_q == CLS_BR) ? S_CMP : S_ALU_WB;
      S_IMM_B:    state_d = ((cls_q == CLS_LW) || (cls_q == CLS_SW)) ? S_ADDR_MA : S_ALU_WB;
      S_ALU_WB:   state_d = S_PCI_A;
      S_ADDR_MA:  state_d = (cls_q == CLS_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = busy ? S_MEM_RD : S_PCI_A;
      S_MEM_WR:   state_d = busy ? S_MEM_WR : S_PCI_A;
      S_CMP:      state_d = taken_s ? S_PCB_A : S_PCI_A;
      S_PCB_A:    state_d = S_PCB_B;
      S_PCB_B:    state_d = S_PCB_WB;
      S_PCB_WB:   state_d = S_FETCH_MA;
      S_PCI_A:    state_d = S_PCI_B;
      S_PCI_B:    state_d = S_PCI_WB;
      S_PCI_WB:   state_d = S_FETCH_MA;
      S_HALT:     state_d = S_HALT;
      // An unreachable encoding restarts the fetch sequence from RESET.
      default:    state_d = S_RESET;
    endcase
  end

  // Moore control strobes; busy only qualifies ldiR and the LW register write.
  always_comb begin
    ALUControl     = alu_op_q;
    lda            = 1'b0;
    ldb            = 1'b0;
    ldma           = 1'b0;
    ldiR           = 1'b0;
    reg_sel        = SEL_RS1;
    reg_en         = 1'b0;
    reg_we         = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    alu_en         = 1'b0;
    IMM_en         = 1'b0;
    ExtendSign_sel = IMM_I;
    instr_done     = 1'b0;
    halted         = 1'b0;
    case (state_q)
      S_RESET: begin
        ALUControl = ALU_ADD;
      end
      S_FETCH_MA: begin
        reg_sel = SEL_PC;
        reg_en  = 1'b1;
        ldma    = 1'b1;
      end
      S_FETCH_IR: begin
        mem_en = 1'b1;
        ldiR   = ~busy;
      end
      S_DECODE: begin
        ALUControl = alu_op_q;
      end
      S_RS1_A: begin
        reg_sel = SEL_RS1;
        reg_en  = 1'b1;
        lda     = 1'b1;
      end
      S_RS2_B: begin
        reg_sel = SEL_RS2;
        reg_en  = 1'b1;
        ldb     = 1'b1;
      end
      S_IMM_B: begin
        IMM_en = 1'b1;
        ldb    = 1'b1;
        if (cls_q == CLS_SW) begin
          ExtendSign_sel = IMM_S;
        end else begin
          ExtendSign_sel = IMM_I;
        end
      end
      S_ALU_WB: begin
        alu_en  = 1'b1;
        reg_sel = SEL_RD;
        reg_en  = ~rd_zero_q;
        reg_we  = ~rd_zero_q;
      end
      S_ADDR_MA: begin
        ALUControl = ALU_ADD;
        alu_en     = 1'b1;
        ldma       = 1'b1;
      end
      S_MEM_RD: begin
        mem_en  = 1'b1;
        reg_sel = SEL_RD;
        reg_en  = ~busy & ~rd_zero_q;
        reg_we  = ~busy & ~rd_zero_q;
      end
      S_MEM_WR: begin
        // rs2 stays on the bus as write data for the whole access.
        mem_en  = 1'b1;
        mem_we  = 1'b1;
        reg_sel = SEL_RS2;
        reg_en  = 1'b1;
      end
      S_CMP: begin
        ALUControl = ALU_SUB;
      end
      S_PCB_A, S_PCI_A: begin
        reg_sel = SEL_PC;
        reg_en  = 1'b1;
        lda     = 1'b1;
      end
      S_PCB_B: begin
        IMM_en         = 1'b1;
        ExtendSign_sel = IMM_B;
        ldb            = 1'b1;
      end
      S_PCI_B: begin
        IMM_en         = 1'b1;
        ExtendSign_sel = IMM_FOUR;
        ldb            = 1'b1;
      end
      S_PCB_WB, S_PCI_WB: begin
        ALUControl = ALU_ADD;
        alu_en     = 1'b1;
        reg_sel    = SEL_PC;
        reg_en     = 1'b1;
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        ALUControl = ALU_ADD;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Cycle-accurate self-checking bench for multicycle_ctrl. Expected control
// words come either from a literal table (ADD) or from an instruction-level
// reference model that expands one instruction plus its memory wait counts
// into the per-cycle list of control words. Inputs are driven on the falling
// edge and outputs compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] alu;
    logic       lda;
    logic       ldb;
    logic       ldma;
    logic       ldir;
    logic [1:0] rsel;
    logic       ren;
    logic       rwe;
    logic       men;
    logic       mwe;
    logic       aluen;
    logic       immen;
    logic [1:0] ext;
    logic       done;
    logic       halted;
  } outs_t;

  typedef struct {
    logic        busy;
    logic        zero;
    logic [31:0] ins;
    outs_t       exp;
    string       tag;
  } vec_t;

  localparam int CL_R = 0, CL_I = 1, CL_LW = 2, CL_SW = 3, CL_BR = 4, CL_HALT = 5;
  // ALU op by funct3 (funct3=7 in the top nibble): AND OR SRL XOR SLT SLT SLL ADD
  localparam logic [31:0] F3_OPS = 32'h2374_5560;
  localparam logic [3:0]  OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SRA = 4'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        zero = 1'b0;
  logic        busy = 1'b0;
  logic [3:0]  ALUControl;
  logic        lda, ldb, ldma, ldiR, reg_en, reg_we, mem_en, mem_we, alu_en, IMM_en;
  logic        instr_done, halted;
  logic [1:0]  reg_sel, ExtendSign_sel;
  outs_t       act;

  int          checks = 0;
  int          failures = 0;
  logic [3:0]  held_op = 4'd0;
  vec_t        trace[$];
  vec_t        add_tbl[9];

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .busy(busy),
    .ALUControl(ALUControl), .lda(lda), .ldb(ldb), .ldma(ldma), .ldiR(ldiR),
    .reg_sel(reg_sel), .reg_en(reg_en), .reg_we(reg_we), .mem_en(mem_en),
    .mem_we(mem_we), .alu_en(alu_en), .IMM_en(IMM_en),
    .ExtendSign_sel(ExtendSign_sel), .instr_done(instr_done), .halted(halted)
  );

  assign act = {ALUControl, lda, ldb, ldma, ldiR, reg_sel, reg_en, reg_we,
                mem_en, mem_we, alu_en, IMM_en, ExtendSign_sel, instr_done, halted};

  always #5 clk = ~clk;

  function automatic outs_t mk(input int a, input int la, input int lb, input int lma,
                               input int lir, input int rs, input int re, input int rw,
                               input int me, input int mw, input int ae, input int ie,
                               input int ex, input int d, input int h);
    outs_t o;
    o.alu = 4'(a);  o.lda = 1'(la);  o.ldb = 1'(lb);  o.ldma = 1'(lma);
    o.ldir = 1'(lir); o.rsel = 2'(rs); o.ren = 1'(re); o.rwe = 1'(rw);
    o.men = 1'(me);  o.mwe = 1'(mw); o.aluen = 1'(ae); o.immen = 1'(ie);
    o.ext = 2'(ex); o.done = 1'(d);  o.halted = 1'(h);
    return o;
  endfunction

  function automatic vec_t mkv(input logic b, input logic z, input logic [31:0] ins,
                               input outs_t e, input string t);
    vec_t v;
    v.busy = b; v.zero = z; v.ins = ins; v.exp = e; v.tag = t;
    return v;
  endfunction

  function automatic int ref_class(input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    if (ins[6:0] == 7'b0110011) return CL_R;
    if (ins[6:0] == 7'b0010011) return CL_I;
    if (ins[6:0] == 7'b0000011 && f3 == 3'd2) return CL_LW;
    if (ins[6:0] == 7'b0100011 && f3 == 3'd2) return CL_SW;
    if (ins[6:0] == 7'b1100011 && f3 <= 3'd1) return CL_BR;
    return CL_HALT;
  endfunction

  function automatic logic [3:0] ref_op(input logic [31:0] ins);
    int         cls;
    logic [3:0] op;
    int         f3;
    cls = ref_class(ins);
    f3  = int'(ins[14:12]);
    if (cls == CL_BR) return OP_SUB;
    if (cls != CL_R && cls != CL_I) return OP_ADD;
    op = F3_OPS[f3*4 +: 4];
    if (cls == CL_R && f3 == 0 && ins[30]) op = OP_SUB;
    if (f3 == 5 && ins[30]) op = OP_SRA;
    return op;
  endfunction

  task automatic push(input logic b, input logic [31:0] ins, input outs_t o, input string t);
    logic z;
    z = 1'($urandom);
    trace.push_back(mkv(b, z, ins, o, t));
  endtask

  // Expand one instruction into its cycle-by-cycle control words.
  task automatic gen_instr(input logic [31:0] ins, input int fw, input int mw, input logic zr);
    outs_t o;
    int    cls;
    logic  wr;
    logic  taken;
    cls   = ref_class(ins);
    wr    = (ins[11:7] != 5'd0);
    taken = 1'b0;
    o = '0; o.alu = held_op; o.rsel = 2'd3; o.ren = 1'b1; o.ldma = 1'b1;
    push(1'b0, ins, o, "fetch_ma");
    for (int k = 0; k < fw; k++) begin
      o = '0; o.alu = held_op; o.men = 1'b1;
      push(1'b1, ins, o, "fetch_wait");
    end
    o = '0; o.alu = held_op; o.men = 1'b1; o.ldir = 1'b1;
    push(1'b0, ins, o, "fetch_ir");
    o = '0; o.alu = held_op;
    push(1'b0, ins, o, "decode");
    held_op = ref_op(ins);
    if (cls == CL_HALT) return;
    o = '0; o.alu = held_op; o.rsel = 2'd0; o.ren = 1'b1; o.lda = 1'b1;
    push(1'b0, ins, o, "rs1_a");
    o = '0; o.alu = held_op; o.ldb = 1'b1;
    if (cls == CL_R || cls == CL_BR) begin
      o.rsel = 2'd1; o.ren = 1'b1;
    end else begin
      o.immen = 1'b1; o.ext = (cls == CL_SW) ? 2'b01 : 2'b00;
    end
    push(1'b0, ins, o, "opnd_b");
    if (cls == CL_R || cls == CL_I) begin
      o = '0; o.alu = held_op; o.aluen = 1'b1; o.rsel = 2'd2; o.ren = wr; o.rwe = wr;
      push(1'b0, ins, o, "alu_wb");
    end else if (cls == CL_BR) begin
      o = '0; o.alu = OP_SUB;
      taken = ins[12] ? ~zr : zr;
      trace.push_back(mkv(1'b0, zr, ins, o, "cmp"));
    end else begin
      o = '0; o.alu = OP_ADD; o.aluen = 1'b1; o.ldma = 1'b1;
      push(1'b0, ins, o, "addr_ma");
      for (int k = 0; k <= mw; k++) begin
        o = '0; o.alu = held_op; o.men = 1'b1;
        if (cls == CL_LW) begin
          o.rsel = 2'd2; o.ren = (k == mw) && wr; o.rwe = (k == mw) && wr;
        end else begin
          o.mwe = 1'b1; o.rsel = 2'd1; o.ren = 1'b1;
        end
        push(k < mw, ins, o, (cls == CL_LW) ? "mem_rd" : "mem_wr");
      end
    end
    o = '0; o.alu = held_op; o.rsel = 2'd3; o.ren = 1'b1; o.lda = 1'b1;
    push(1'b0, ins, o, "pc_a");
    o = '0; o.alu = held_op; o.immen = 1'b1; o.ldb = 1'b1; o.ext = taken ? 2'b10 : 2'b11;
    push(1'b0, ins, o, "pc_b");
    o = '0; o.alu = OP_ADD; o.aluen = 1'b1; o.rsel = 2'd3; o.ren = 1'b1; o.rwe = 1'b1;
    o.done = 1'b1;
    push(1'b0, ins, o, "pc_wb");
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0]  f3;
    logic [4:0]  rd;
    int          k;
    r  = $urandom;
    k  = $urandom_range(0, 4);
    f3 = 3'($urandom_range(0, 7));
    if (f3 == 3'd3) f3 = 3'd4;
    rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    case (k)
      0:       return {1'b0, r[30], 5'd0, r[24:15], f3, rd, 7'b0110011};
      1:       return {r[31:15], f3, rd, 7'b0010011};
      2:       return {r[31:15], 3'b010, rd, 7'b0000011};
      3:       return {r[31:15], 3'b010, r[11:7], 7'b0100011};
      default: return {r[31:15], 2'b00, r[12], r[11:7], 7'b1100011};
    endcase
  endfunction

  task automatic check(input outs_t exp, input string tag);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t: got %05h expected %05h (alu=%h/%h sel=%0d/%0d ext=%0d/%0d)",
               tag, $time, act, exp, act.alu, exp.alu, act.rsel, exp.rsel, act.ext, exp.ext);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    busy  = v.busy;
    zero  = v.zero;
    instr = v.ins;
    #1;
    check(v.exp, v.tag);
  endtask

  task automatic run_trace(input int limit);
    int n;
    n = 0;
    while (trace.size() != 0 && n < limit) begin
      apply(trace.pop_front());
      n++;
    end
    trace.delete();
  endtask

  // Assert rst off-edge, check the immediate clear, then release.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check('0, tag);
    @(negedge clk);
    #1;
    check('0, "rst_hold");
    rst  = 1'b0;
    busy = 1'b0;
    #1;
    check('0, "post_rst_state");
    held_op = 4'd0;
  endtask

  initial begin
    add_tbl[0] = mkv(1'b0, 1'b0, 32'h002081B3, mk(0,0,0,1,0,3,1,0,0,0,0,0,0,0,0), "add_fetch_ma");
    add_tbl[1] = mkv(1'b0, 1'b1, 32'h002081B3, mk(0,0,0,0,1,0,0,0,1,0,0,0,0,0,0), "add_fetch_ir");
    add_tbl[2] = mkv(1'b0, 1'b0, 32'h002081B3, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "add_decode");
    add_tbl[3] = mkv(1'b0, 1'b1, 32'h002081B3, mk(0,1,0,0,0,0,1,0,0,0,0,0,0,0,0), "add_rs1_a");
    add_tbl[4] = mkv(1'b0, 1'b0, 32'h002081B3, mk(0,0,1,0,0,1,1,0,0,0,0,0,0,0,0), "add_rs2_b");
    add_tbl[5] = mkv(1'b0, 1'b1, 32'h002081B3, mk(0,0,0,0,0,2,1,1,0,0,1,0,0,0,0), "add_alu_wb");
    add_tbl[6] = mkv(1'b0, 1'b0, 32'h002081B3, mk(0,1,0,0,0,3,1,0,0,0,0,0,0,0,0), "add_pci_a");
    add_tbl[7] = mkv(1'b0, 1'b1, 32'h002081B3, mk(0,0,1,0,0,0,0,0,0,0,0,1,3,0,0), "add_pci_b");
    add_tbl[8] = mkv(1'b0, 1'b0, 32'h002081B3, mk(0,0,0,0,0,3,1,1,0,0,1,0,0,1,0), "add_pci_wb");

    // Reset held for three cycles, then the RESET state, then FETCH_MA.
    repeat (3) begin
      @(negedge clk);
      #1;
      check('0, "in_reset");
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check('0, "reset_state");

    for (int i = 0; i < 9; i++) apply(add_tbl[i]);
    held_op = ref_op(32'h002081B3);

    // LW x5,8(x1): 3 fetch waits, 2 read waits -> 15 cycles.
    gen_instr(32'h0080A283, 3, 2, 1'b0);
    run_trace(1000);
    // SW x2,4(x1) with one write wait.
    gen_instr(32'h0020A223, 0, 1, 1'b0);
    run_trace(1000);
    // BEQ taken, BNE not taken (zero=1 for both).
    gen_instr(32'h00208463, 0, 0, 1'b1);
    run_trace(1000);
    gen_instr(32'h00209463, 0, 0, 1'b1);
    run_trace(1000);
    // ADDI x0,x0,5: write suppressed, still 9 cycles.
    gen_instr(32'h00500013, 0, 0, 1'b0);
    run_trace(1000);
    // SUB and SRAI / ADDI with bit 30 set.
    gen_instr(32'h402081B3, 0, 0, 1'b0);
    run_trace(1000);
    gen_instr(32'h4030D193, 1, 0, 1'b0);
    run_trace(1000);
    gen_instr(32'h40308193, 0, 0, 1'b0);
    run_trace(1000);

    for (int i = 0; i < 200; i++) begin
      gen_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      run_trace(1000);
    end

    // Reset in the middle of an LW read wait.
    gen_instr(32'h0080A283, 0, 3, 1'b0);
    run_trace(8);
    async_reset("async_rst_mid_instr");
    gen_instr(32'h002081B3, 0, 0, 1'b0);
    run_trace(1000);

    // Illegal opcode halts; reset mid-HALT recovers.
    gen_instr(32'h0000007F, 1, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      outs_t o;
      o = '0; o.alu = held_op; o.halted = 1'b1;
      push(1'($urandom), 32'h0000007F, o, "halt");
    end
    run_trace(1000);
    async_reset("async_rst_halt");
    gen_instr(32'h00500093, 0, 0, 1'b0);
    run_trace(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
